// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and helpers for the UART command parser.
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_W    = 8'h57;
    localparam logic [7:0] ASCII_W_LC = 8'h77;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_R_LC = 8'h72;
    localparam logic [7:0] ASCII_K    = 8'h4B;
    localparam logic [7:0] ASCII_Q    = 8'h3F;

    // "K"/"?" + CR LF, or two hex digits + CR LF
    localparam logic [2:0] RESP_LEN_ACK = 3'd3;
    localparam logic [2:0] RESP_LEN_RD  = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_TERM,
        S_EXEC,
        S_RD_WAIT,
        S_RESP,
        S_DISCARD
    } state_t;

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

    function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/uart_hex_codec.sv
// ASCII hex digit to nibble (with valid flag) and byte to two uppercase ASCII digits.
module uart_hex_codec
    import uart_cmd_pkg::*;
(
    input  logic [7:0] asc_i,
    output logic [3:0] nib_o,
    output logic       nib_vld_o,
    input  logic [7:0] byte_i,
    output logic [7:0] hex_hi_o,
    output logic [7:0] hex_lo_o
);

    logic [7:0] diff;

    // Decode one ASCII character: 0-9, A-F, a-f are legal digits
    always_comb begin
        diff      = 8'h00;
        nib_o     = 4'h0;
        nib_vld_o = 1'b0;
        if (asc_i >= 8'h30 && asc_i <= 8'h39) begin
            diff      = asc_i - 8'h30;
            nib_vld_o = 1'b1;
        end else if (asc_i >= 8'h41 && asc_i <= 8'h46) begin
            diff      = asc_i - 8'h37;
            nib_vld_o = 1'b1;
        end else if (asc_i >= 8'h61 && asc_i <= 8'h66) begin
            diff      = asc_i - 8'h57;
            nib_vld_o = 1'b1;
        end
        nib_o = diff[3:0];
    end

    assign hex_hi_o = nib_to_ascii(byte_i[7:4]);
    assign hex_lo_o = nib_to_ascii(byte_i[3:0]);

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command parser: "Waadd<term>" writes, "Raa<term>" reads, replies via UART tx.
//
// tx handshake: a byte moves only in a cycle where tx_send=1, and tx_send is
// never raised unless tx_ready=1 that same cycle. tx_data comes straight from
// registers so it never depends on tx_ready.
module uart_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 4000000,
    parameter int          ECHO_EN        = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_send,
    output logic [7:0] tx_data,
    output logic       reg_wr,
    output logic       reg_rd,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       err
);
    import uart_cmd_pkg::*;

    localparam bit          TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam int          TW       = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    state_t          state_q, state_d;
    logic            write_q, write_d;
    logic [7:0]      addr_p_q, addr_p_d;
    logic [7:0]      data_p_q, data_p_d;
    logic [7:0]      reg_addr_q, reg_addr_d;
    logic [7:0]      reg_wdata_q, reg_wdata_d;
    logic [3:0][7:0] resp_q, resp_d;
    logic [2:0]      len_q, len_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            echo_pend_q, echo_pend_d;
    logic [7:0]      echo_byte_q, echo_byte_d;

    logic [3:0] rx_nib;
    logic       rx_hex;
    logic [7:0] rd_hi, rd_lo;
    logic       rx_term, counting, busy, timed_out;
    logic       syntax_err, echo_fire, resp_fire;

    uart_hex_codec u_codec (
        .asc_i    (rx_data),
        .nib_o    (rx_nib),
        .nib_vld_o(rx_hex),
        .byte_i   (reg_rdata),
        .hex_hi_o (rd_hi),
        .hex_lo_o (rd_lo)
    );

    // Next-state, response buffer, timeout counter and strobes
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_p_d    = addr_p_q;
        data_p_d    = data_p_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        resp_d      = resp_q;
        len_d       = len_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        echo_pend_d = echo_pend_q;
        echo_byte_d = echo_byte_q;
        reg_wr      = 1'b0;
        reg_rd      = 1'b0;
        syntax_err  = 1'b0;

        rx_term   = is_term(rx_data);
        counting  = state_q inside {S_ADDR_HI, S_ADDR_LO, S_DATA_HI, S_DATA_LO, S_TERM, S_DISCARD};
        busy      = state_q inside {S_EXEC, S_RD_WAIT, S_RESP};
        timed_out = TO_EN && counting && !rx_valid && (cnt_q == TO_LIMIT);
        // A pending echo byte goes out ahead of the response.
        echo_fire = echo_pend_q && tx_ready;
        resp_fire = (state_q == S_RESP) && tx_ready && !echo_pend_q;
        tx_send   = echo_fire || resp_fire;

        if (!counting || rx_valid) begin
            cnt_d = '0;
        end else if (TO_EN) begin
            cnt_d = cnt_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == ASCII_W || rx_data == ASCII_W_LC) begin
                        write_d = 1'b1;
                        state_d = S_ADDR_HI;
                    end else if (rx_data == ASCII_R || rx_data == ASCII_R_LC) begin
                        write_d = 1'b0;
                        state_d = S_ADDR_HI;
                    end else if (!rx_term && rx_data != ASCII_SP) begin
                        err_d   = 1'b1;
                        state_d = S_DISCARD;
                    end
                end
            end
            S_ADDR_HI: begin
                if (rx_valid) begin
                    if (rx_hex) begin
                        addr_p_d[7:4] = rx_nib;
                        state_d       = S_ADDR_LO;
                    end else begin
                        syntax_err = 1'b1;
                    end
                end
            end
            S_ADDR_LO: begin
                if (rx_valid) begin
                    if (rx_hex) begin
                        addr_p_d[3:0] = rx_nib;
                        state_d       = write_q ? S_DATA_HI : S_TERM;
                    end else begin
                        syntax_err = 1'b1;
                    end
                end
            end
            S_DATA_HI: begin
                if (rx_valid) begin
                    if (rx_hex) begin
                        data_p_d[7:4] = rx_nib;
                        state_d       = S_DATA_LO;
                    end else begin
                        syntax_err = 1'b1;
                    end
                end
            end
            S_DATA_LO: begin
                if (rx_valid) begin
                    if (rx_hex) begin
                        data_p_d[3:0] = rx_nib;
                        state_d       = S_TERM;
                    end else begin
                        syntax_err = 1'b1;
                    end
                end
            end
            S_TERM: begin
                if (rx_valid) begin
                    if (rx_term) begin
                        reg_addr_d = addr_p_q;
                        if (write_q) begin
                            reg_wdata_d = data_p_q;
                        end
                        state_d = S_EXEC;
                    end else begin
                        syntax_err = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (write_q) begin
                    reg_wr    = 1'b1;
                    resp_d    = {8'h00, ASCII_LF, ASCII_CR, ASCII_K};
                    len_d     = RESP_LEN_ACK;
                    idx_d     = 2'd0;
                    tx_data_d = ASCII_K;
                    state_d   = S_RESP;
                end else begin
                    reg_rd  = 1'b1;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                resp_d    = {ASCII_LF, ASCII_CR, rd_lo, rd_hi};
                len_d     = RESP_LEN_RD;
                idx_d     = 2'd0;
                tx_data_d = rd_hi;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (resp_fire) begin
                    if ({1'b0, idx_q} == len_q - 3'd1) begin
                        idx_d   = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_data_d = resp_q[idx_q + 2'd1];
                    end
                end
            end
            S_DISCARD: begin
                if (rx_valid && rx_term) begin
                    resp_d    = {8'h00, ASCII_LF, ASCII_CR, ASCII_Q};
                    len_d     = RESP_LEN_ACK;
                    idx_d     = 2'd0;
                    tx_data_d = ASCII_Q;
                    state_d   = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A bad byte that is itself a terminator already ends the frame, so
        // answer "?" at once instead of waiting for a second terminator.
        if (syntax_err) begin
            err_d = 1'b1;
            if (rx_term) begin
                resp_d    = {8'h00, ASCII_LF, ASCII_CR, ASCII_Q};
                len_d     = RESP_LEN_ACK;
                idx_d     = 2'd0;
                tx_data_d = ASCII_Q;
                state_d   = S_RESP;
            end else begin
                state_d = S_DISCARD;
            end
        end

        if (timed_out) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end

        // Overrun: byte arrives while a command is executing or replying.
        if (rx_valid && busy) begin
            err_d = 1'b1;
        end

        // Single-byte echo slot; a newer byte overwrites one not yet sent.
        if (echo_fire) begin
            echo_pend_d = 1'b0;
        end
        if (ECHO_EN != 0 && rx_valid && !busy) begin
            echo_pend_d = 1'b1;
            echo_byte_d = rx_data;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            addr_p_q    <= 8'h00;
            data_p_q    <= 8'h00;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            resp_q      <= '0;
            len_q       <= RESP_LEN_ACK;
            idx_q       <= 2'd0;
            tx_data_q   <= 8'h00;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            echo_pend_q <= 1'b0;
            echo_byte_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_p_q    <= addr_p_d;
            data_p_q    <= data_p_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            resp_q      <= resp_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            echo_pend_q <= echo_pend_d;
            echo_byte_q <= echo_byte_d;
        end
    end

    assign tx_data   = echo_pend_q ? echo_byte_q : tx_data_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frame table plus timeout, backpressure and reset sequences.
module tb_uart_cmd_parser;

    localparam int         TO = 1000;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef struct {
        logic [63:0] frame;
        int          flen;
        logic [7:0]  rdata;
        int          exp_wr;
        int          exp_rd;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_wdata;
        int          exp_err;
        logic [31:0] exp_tx;
        int          exp_txn;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_ready = 1'b1;
    logic       tx_send;
    logic [7:0] tx_data;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;
    logic       err;

    uart_cmd_parser #(.TIMEOUT_CYCLES(TO), .ECHO_EN(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_ready (tx_ready),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .reg_wr   (reg_wr),
        .reg_rd   (reg_rd),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .err      (err)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: sampled on the falling edge
    int         wr_cnt = 0, rd_cnt = 0, err_cnt = 0, viol_cnt = 0;
    int         last_rx_cyc = 0, wr_cyc = 0, rd_cyc = 0;
    logic [7:0] wr_addr = 8'h00, wr_data = 8'h00, rd_addr = 8'h00;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) last_rx_cyc = cyc;
            if (reg_wr) begin
                wr_cnt++;
                wr_addr = reg_addr;
                wr_data = reg_wdata;
                wr_cyc  = cyc;
            end
            if (reg_rd) begin
                rd_cnt++;
                rd_addr = reg_addr;
                rd_cyc  = cyc;
            end
            if (err) err_cnt++;
            if (tx_send) begin
                got_q.push_back(tx_data);
                if (!tx_ready) viol_cnt++;
            end
        end
    end

    // scoreboard
    logic [7:0] exp_q[$];
    int         got_rd = 0;
    int         checks = 0;
    int         errors = 0;
    vec_t       vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic expect_tx(input logic [31:0] bytes, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(bytes[8*(n-1-i) +: 8]);
    endtask

    task automatic check_tx(input string name);
        logic [7:0] e, g;
        check({name, "_txn"}, got_q.size() - got_rd, exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_rd < got_q.size()) ? got_q[got_rd] : 8'hxx;
            got_rd++;
            check({name, "_txbyte"}, {24'h0, g}, {24'h0, e});
        end
        got_rd = got_q.size();
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [63:0] f, input int n);
        for (int i = 0; i < n; i++) send_byte(f[8*(n-1-i) +: 8]);
    endtask

    task automatic run_vec(input int k);
        int b_wr, b_rd, b_err;
        string nm;
        nm    = $sformatf("v%0d", k);
        b_wr  = wr_cnt;
        b_rd  = rd_cnt;
        b_err = err_cnt;
        reg_rdata = vecs[k].rdata;
        expect_tx(vecs[k].exp_tx, vecs[k].exp_txn);
        send_frame(vecs[k].frame, vecs[k].flen);
        repeat (30) @(posedge clk);
        #1;
        check({nm, "_wr_count"}, wr_cnt - b_wr, vecs[k].exp_wr);
        if (vecs[k].exp_wr > 0) begin
            check({nm, "_wr_addr"}, {24'h0, wr_addr}, {24'h0, vecs[k].exp_addr});
            check({nm, "_wr_data"}, {24'h0, wr_data}, {24'h0, vecs[k].exp_wdata});
            check({nm, "_wr_latency"}, wr_cyc - last_rx_cyc, 1);
        end
        check({nm, "_rd_count"}, rd_cnt - b_rd, vecs[k].exp_rd);
        if (vecs[k].exp_rd > 0) begin
            check({nm, "_rd_addr"}, {24'h0, rd_addr}, {24'h0, vecs[k].exp_addr});
            check({nm, "_rd_latency"}, rd_cyc - last_rx_cyc, 1);
        end
        check({nm, "_err_count"}, err_cnt - b_err, vecs[k].exp_err);
        check_tx(nm);
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_tx_send"}, {31'h0, tx_send}, 0);
        check({nm, "_reg_wr"}, {31'h0, reg_wr}, 0);
        check({nm, "_reg_rd"}, {31'h0, reg_rd}, 0);
        check({nm, "_err"}, {31'h0, err}, 0);
        check({nm, "_tx_data"}, {24'h0, tx_data}, 0);
        check({nm, "_reg_addr"}, {24'h0, reg_addr}, 0);
        check({nm, "_reg_wdata"}, {24'h0, reg_wdata}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_wr, b_rd, b_err, b_viol;

        vecs[0]  = '{frame: 64'({"W1A5C", CR}), flen: 6, rdata: 8'h00, exp_wr: 1, exp_rd: 0,
                     exp_addr: 8'h1A, exp_wdata: 8'h5C, exp_err: 0, exp_tx: 32'({8'h4B, CR, LF}), exp_txn: 3};
        vecs[1]  = '{frame: 64'({"r1a", LF}), flen: 4, rdata: 8'hB3, exp_wr: 0, exp_rd: 1,
                     exp_addr: 8'h1A, exp_wdata: 8'h00, exp_err: 0, exp_tx: {8'h42, 8'h33, CR, LF}, exp_txn: 4};
        vecs[2]  = '{frame: 64'({"W1G", CR}), flen: 4, rdata: 8'h00, exp_wr: 0, exp_rd: 0,
                     exp_addr: 8'h00, exp_wdata: 8'h00, exp_err: 1, exp_tx: 32'({8'h3F, CR, LF}), exp_txn: 3};
        vecs[3]  = '{frame: 64'({"w00ff", LF}), flen: 6, rdata: 8'h00, exp_wr: 1, exp_rd: 0,
                     exp_addr: 8'h00, exp_wdata: 8'hFF, exp_err: 0, exp_tx: 32'({8'h4B, CR, LF}), exp_txn: 3};
        vecs[4]  = '{frame: 64'({"R7F", CR}), flen: 4, rdata: 8'h5A, exp_wr: 0, exp_rd: 1,
                     exp_addr: 8'h7F, exp_wdata: 8'h00, exp_err: 0, exp_tx: {8'h35, 8'h41, CR, LF}, exp_txn: 4};
        vecs[5]  = '{frame: 64'({" ", CR, "X", LF}), flen: 4, rdata: 8'h00, exp_wr: 0, exp_rd: 0,
                     exp_addr: 8'h00, exp_wdata: 8'h00, exp_err: 1, exp_tx: 32'({8'h3F, CR, LF}), exp_txn: 3};
        vecs[6]  = '{frame: 64'({"Wab1Z", CR}), flen: 6, rdata: 8'h00, exp_wr: 0, exp_rd: 0,
                     exp_addr: 8'h00, exp_wdata: 8'h00, exp_err: 1, exp_tx: 32'({8'h3F, CR, LF}), exp_txn: 3};
        vecs[7]  = '{frame: 64'({"RF0x", CR}), flen: 5, rdata: 8'h00, exp_wr: 0, exp_rd: 0,
                     exp_addr: 8'h00, exp_wdata: 8'h00, exp_err: 1, exp_tx: 32'({8'h3F, CR, LF}), exp_txn: 3};
        vecs[8]  = '{frame: 64'({"W0001", CR}), flen: 6, rdata: 8'h00, exp_wr: 1, exp_rd: 0,
                     exp_addr: 8'h00, exp_wdata: 8'h01, exp_err: 0, exp_tx: 32'({8'h4B, CR, LF}), exp_txn: 3};
        vecs[9]  = '{frame: 64'({"R00", CR}), flen: 4, rdata: 8'h3C, exp_wr: 0, exp_rd: 1,
                     exp_addr: 8'h00, exp_wdata: 8'h00, exp_err: 0, exp_tx: {8'h33, 8'h43, CR, LF}, exp_txn: 4};
        vecs[10] = '{frame: 64'({"R42", CR}), flen: 4, rdata: 8'h9E, exp_wr: 0, exp_rd: 1,
                     exp_addr: 8'h42, exp_wdata: 8'h00, exp_err: 0, exp_tx: {8'h39, 8'h45, CR, LF}, exp_txn: 4};

        // reset
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("post_reset");

        // table of frames
        for (int k = 0; k < 8; k++) run_vec(k);

        // timeout: partial frame then silence
        b_wr  = wr_cnt;
        b_err = err_cnt;
        send_frame(64'("W1"), 2);
        repeat (980) @(posedge clk);
        #1;
        check("timeout_early_err", err_cnt - b_err, 0);
        repeat (40) @(posedge clk);
        #1;
        check("timeout_err", err_cnt - b_err, 1);
        check("timeout_no_wr", wr_cnt - b_wr, 0);
        check_tx("timeout");
        run_vec(9);

        // backpressure, plus an overrun byte while replying
        b_rd   = rd_cnt;
        b_err  = err_cnt;
        b_viol = viol_cnt;
        tx_ready  = 1'b0;
        reg_rdata = vecs[10].rdata;
        send_frame(vecs[10].frame, vecs[10].flen);
        repeat (5) @(posedge clk);
        #1;
        send_byte("W");
        repeat (40) @(posedge clk);
        #1;
        check("bp_held_txn", got_q.size() - got_rd, 0);
        check("bp_overrun_err", err_cnt - b_err, 1);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            tx_ready = ~tx_ready;
        end
        tx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("bp_rd_count", rd_cnt - b_rd, 1);
        check("bp_rd_addr", {24'h0, rd_addr}, 32'h42);
        check("bp_send_while_busy", viol_cnt - b_viol, 0);
        expect_tx(vecs[10].exp_tx, vecs[10].exp_txn);
        check_tx("bp");

        // asynchronous reset mid-frame
        send_frame(64'("W12"), 3);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midframe_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_vec(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Byte-stream command parser placed directly downstream of a UART receiver (rx_data/valid) and upstream of a UART transmitter (tx_data/send).
Decodes ASCII frames into single-cycle 8-bit register-bus writes and reads, and returns ASCII acknowledgements or read data through the transmitter.
Replaces ad-hoc per-character LED decoding in top-level logic. Control registers such as LEDs then hang off the register bus.

Parameters:
TIMEOUT_CYCLES, 4000000, clk cycles of rx silence that abort a partial frame (0 = timeout disabled); counter width is clog2(TIMEOUT_CYCLES+1)
ECHO_EN, 0, when 1 every accepted rx byte is also queued for tx before parsing (not used in default build; tests cover 0)

Ports:
clk  input  1  system clock (UART clock domain)
rst_n  input  1  asynchronous active-low reset
rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
rx_data  input  8  received byte
tx_ready  input  1  transmitter can accept a byte this cycle
tx_send  output  1  one-cycle strobe: transmit tx_data; asserted only when tx_ready=1
tx_data  output  8  byte to transmit, valid while tx_send=1
reg_wr  output  1  one-cycle register write strobe
reg_rd  output  1  one-cycle register read strobe
reg_addr  output  8  register address, stable from strobe until next command
reg_wdata  output  8  write data, stable with reg_addr
reg_rdata  input  8  read data, sampled exactly one cycle after reg_rd
err  output  1  one-cycle pulse on syntax error, timeout, or rx overrun

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; tx_send, reg_wr, reg_rd, err=0; tx_data, reg_addr, reg_wdata=0x00; timeout counter=0. A partial frame is discarded.
- Frame grammar:
  - Write: cmd 'W'/'w', then 2 hex addr, then 2 hex data, then terminator.
  - Read: cmd 'R'/'r', then 2 hex addr, then terminator.
  - Hex is 0-9, A-F, a-f, most-significant nibble first. Terminator is CR 0x0D or LF 0x0A.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, TERM, EXEC, RD_WAIT, RESP, DISCARD.
- IDLE:
  - 'W' goes to ADDR_HI with the write flag set; 'R' goes to ADDR_HI with the write flag cleared.
  - CR, LF and space 0x20 are ignored.
  - Any other byte pulses err and goes to DISCARD.
- Parse states:
  - Valid hex shifts into the nibble register and advances.
  - ADDR_LO goes to DATA_HI for a write, or to TERM for a read.
  - DATA_LO goes to TERM.
  - TERM accepts only a terminator and then goes to EXEC.
  - Any illegal byte pulses err and goes to DISCARD.
- DISCARD: waits for a terminator, then loads response "?" CR LF and goes to RESP.
- EXEC (1 cycle):
  - Write: reg_wr=1 with reg_addr/reg_wdata; response "K" CR LF; goes to RESP. reg_wr asserts the cycle after the terminator strobe.
  - Read: reg_rd=1; goes to RD_WAIT.
- RD_WAIT (1 cycle): captures reg_rdata. Response is two uppercase hex chars, then CR LF. Goes to RESP.
- RESP:
  - Response buffer is 4 bytes with a length of 3 or 4 and an index counter.
  - tx_send=1 in any cycle with tx_ready=1; the index advances the same cycle.
  - After the last byte the FSM returns to IDLE.
  - No combinational path from tx_ready to tx_data; tx_data is registered per byte.
- rx during EXEC/RD_WAIT/RESP: the byte is dropped and err pulses (overrun). The FSM is unaffected.
- Timeout:
  - The counter clears on every rx_valid and in IDLE/EXEC/RD_WAIT/RESP.
  - It counts in the parse states and DISCARD.
  - On reaching TIMEOUT_CYCLES the FSM goes to IDLE silently (no response) and err pulses.
  - If rx_valid coincides with expiry, the byte wins: the counter clears and the byte is processed.
- ECHO_EN=1 is outside this revision's verification scope.

Decomposition:
- Shared package uart_cmd_pkg:
  - ASCII constants (CR, LF, SP, 'W', 'R', 'K', '?').
  - FSM state encoding.
  - Response length constants.
- One combinational sub-module uart_hex_codec: ascii-to-nibble with a valid flag, and nibble-to-uppercase-ascii.
- The FSM, response buffer and timeout counter stay in uart_cmd_parser.

Test Plan:
- Send "W1A5C\r" with tx_ready=1 -> one reg_wr cycle, reg_addr=0x1A, reg_wdata=0x5C, one cycle after CR; tx bytes 0x4B,0x0D,0x0A; err never set.
- Send "r1a\n" with reg_rdata=0xB3 -> one reg_rd cycle; tx 0x42,0x33,0x0D,0x0A; no reg_wr.
- Send "W1G\r" -> err pulse on 'G'; no reg_wr/reg_rd; tx 0x3F,0x0D,0x0A after CR.
- Send "W1", idle TIMEOUT_CYCLES (TIMEOUT_CYCLES=1000 in the bench) -> err pulse, no tx; then "R00\r" -> normal read response.
- Read with tx_ready held low 50 cycles then toggling every other cycle -> tx_send only when tx_ready=1, 4 bytes in order, none duplicated; a byte received in RESP -> err, dropped.
- Assert rst_n=0 mid-frame after "W12" -> all outputs 0 immediately; after release "W0001\r" -> reg_wr with addr 0x00, data 0x01.
